// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the minterm scanner.
// Imported by the top level and by the settle counter.
package scan_pkg;

  localparam int CODE_W    = 4;
  localparam int N_FULL    = 16;
  localparam int N_BCD     = 10;
  localparam int LAST_FULL = 15;
  localparam int LAST_BCD  = 9;
  localparam int SETTLE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/minterm_scanner_settle_counter.sv
// Down-counter that times how long each input code is held before sampling.
// Loading with n gives n+1 cycles before the zero flag is reached.
module settle_counter
  import scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/minterm_scanner.sv
// Steps {a,b,c,d} through every input code, samples f_in after a settle time
// and compares the captured truth table against an expected table.
module minterm_scanner
  import scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bcd_only,
  input  logic [N_FULL-1:0] expected,
  input  logic              f_in,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              busy,
  output logic              done,
  output logic [N_FULL-1:0] truth_table,
  output logic [4:0]        mismatch_cnt,
  output logic              first_err_vld,
  output logic [CODE_W-1:0] first_err_idx,
  output logic              pass
);

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   idx;
  logic                bcd_q;
  logic [N_FULL-1:0]   exp_q;
  logic                cnt_load;
  logic                settle_zero;
  logic [CODE_W-1:0]   last_idx;
  logic                at_last;
  logic                miss;
  logic [4:0]          cnt_next;

  settle_counter u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
    .zero     (settle_zero)
  );

  assign last_idx = bcd_q ? CODE_W'(LAST_BCD) : CODE_W'(LAST_FULL);
  assign at_last  = (idx == last_idx);
  assign miss     = f_in ^ exp_q[idx];
  assign cnt_next = mismatch_cnt + {4'b0, miss};

  // The stimulus is the idx register itself, so it is registered by construction.
  assign {a, b, c, d} = idx;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          cnt_load  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_zero) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (at_last) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETTLE;
          cnt_load  = 1'b1;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the latched config and expected table are small flops, not a RAM,
  // so they take the synchronous reset like everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      bcd_q         <= 1'b0;
      exp_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth_table   <= '0;
      mismatch_cnt  <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bcd_q         <= bcd_only;
            exp_q         <= expected;
            idx           <= '0;
            truth_table   <= '0;
            mismatch_cnt  <= '0;
            first_err_vld <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          truth_table[idx] <= f_in;
          mismatch_cnt     <= cnt_next;
          if (miss && !first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= idx;
          end
          if (at_last) begin
            // Final verdict includes this last sample, so it is valid during the done pulse.
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (cnt_next == '0);
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: a table of full/BCD scans with f_in = d,
// plus sequences for mid-scan reset, held start and a SETTLE_CYCLES=1 parity scan.
module tb_minterm_scanner;

  logic clk = 1'b0;
  logic rst_n;

  // Instance 1: SETTLE_CYCLES=2, f_in tied to d
  logic        start1, bcd1, f1;
  logic [15:0] exp1;
  logic        a1, b1, c1, d1, busy1, done1, vld1, pass1;
  logic [15:0] tt1;
  logic [4:0]  cnt1;
  logic [3:0]  fidx1;

  // Instance 2: SETTLE_CYCLES=1, f_in = odd parity of the code
  logic        start2, bcd2, f2;
  logic [15:0] exp2;
  logic        a2, b2, c2, d2, busy2, done2, vld2, pass2;
  logic [15:0] tt2;
  logic [4:0]  cnt2;
  logic [3:0]  fidx2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign f1 = d1;
  assign f2 = a2 ^ b2 ^ c2 ^ d2;

  minterm_scanner #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bcd_only(bcd1), .expected(exp1),
    .f_in(f1), .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .truth_table(tt1), .mismatch_cnt(cnt1), .first_err_vld(vld1),
    .first_err_idx(fidx1), .pass(pass1)
  );

  minterm_scanner #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bcd_only(bcd2), .expected(exp2),
    .f_in(f2), .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2),
    .truth_table(tt2), .mismatch_cnt(cnt2), .first_err_vld(vld2),
    .first_err_idx(fidx2), .pass(pass2)
  );

  typedef struct {
    string       name;
    logic        bcd;
    logic [15:0] expv;
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic        vld;
    logic [3:0]  fidx;
    logic        pass;
    int          done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Starts a scan on the selected instance and returns the cycle in which done
  // is high (start-sampling edge = cycle 0), or -1 if it never came.
  task automatic run_scan(input int which, input logic bcd, input logic [15:0] e,
                          output int cyc);
    int n;
    logic dn;
    @(negedge clk);
    if (which == 1) begin bcd1 = bcd; exp1 = e; start1 = 1'b1; end
    else            begin bcd2 = bcd; exp2 = e; start2 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    n = 0;
    dn = (which == 1) ? done1 : done2;
    while (!dn && n < 200) begin
      @(negedge clk);
      n++;
      dn = (which == 1) ? done1 : done2;
    end
    cyc = dn ? n + 1 : -1;
  endtask

  task automatic check_reset1(input string tag);
    check({tag, " abcd"},  32'({a1, b1, c1, d1}), 32'd0);
    check({tag, " busy"},  32'(busy1), 32'd0);
    check({tag, " done"},  32'(done1), 32'd0);
    check({tag, " table"}, 32'(tt1), 32'd0);
    check({tag, " cnt"},   32'(cnt1), 32'd0);
    check({tag, " vld"},   32'(vld1), 32'd0);
    check({tag, " fidx"},  32'(fidx1), 32'd0);
    check({tag, " pass"},  32'(pass1), 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    int ncodes;
    logic seq_ok;
    logic [3:0] prev_code;
    logic drop_start;

    vecs[0] = '{"full_match",   1'b0, 16'hAAAA, 16'hAAAA, 5'd0,  1'b0, 4'd0,  1'b1, 49};
    vecs[1] = '{"full_err0",    1'b0, 16'hAAAB, 16'hAAAA, 5'd1,  1'b1, 4'd0,  1'b0, 49};
    vecs[2] = '{"bcd_match",    1'b1, 16'hFEAA, 16'h02AA, 5'd0,  1'b0, 4'd0,  1'b1, 31};
    vecs[3] = '{"full_all_bad", 1'b0, 16'h5555, 16'hAAAA, 5'd16, 1'b1, 4'd0,  1'b0, 49};
    vecs[4] = '{"full_err15",   1'b0, 16'h2AAA, 16'hAAAA, 5'd1,  1'b1, 4'd15, 1'b0, 49};
    vecs[5] = '{"bcd_zeros",    1'b1, 16'h0000, 16'h02AA, 5'd5,  1'b1, 4'd1,  1'b0, 31};

    rst_n = 1'b0;
    start1 = 1'b0; bcd1 = 1'b0; exp1 = '0;
    start2 = 1'b0; bcd2 = 1'b0; exp2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset1("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_scan(1, vecs[i].bcd, vecs[i].expv, cyc);
      check({vecs[i].name, " done_cycle"}, 32'(cyc), 32'(vecs[i].done_cyc));
      check({vecs[i].name, " busy_at_done"}, 32'(busy1), 32'd0);
      check({vecs[i].name, " table"}, 32'(tt1), 32'(vecs[i].tt));
      check({vecs[i].name, " cnt"},   32'(cnt1), 32'(vecs[i].cnt));
      check({vecs[i].name, " vld"},   32'(vld1), 32'(vecs[i].vld));
      if (vecs[i].vld) check({vecs[i].name, " fidx"}, 32'(fidx1), 32'(vecs[i].fidx));
      check({vecs[i].name, " pass"},  32'(pass1), 32'(vecs[i].pass));
      repeat (3) @(negedge clk);
      check({vecs[i].name, " hold_table"}, 32'(tt1), 32'(vecs[i].tt));
      check({vecs[i].name, " hold_pass"},  32'(pass1), 32'(vecs[i].pass));
      check({vecs[i].name, " done_pulse"}, 32'(done1), 32'd0);
    end

    // Mid-scan reset at cycle 20: partial scan discarded, no done afterwards.
    @(negedge clk);
    bcd1 = 1'b0; exp1 = 16'hAAAA; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset1("midreset");
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done1 || busy1) ndone++;
    end
    check("midreset no_activity", 32'(ndone), 32'd0);
    run_scan(1, 1'b0, 16'hAAAA, cyc);
    check("after_reset done_cycle", 32'(cyc), 32'd49);
    check("after_reset table", 32'(tt1), 32'hAAAA);
    check("after_reset pass",  32'(pass1), 32'd1);

    // Start held through the scan and the DONE cycle: one scan, codes 0..15 once each.
    @(negedge clk);
    bcd1 = 1'b0; exp1 = 16'hAAAA; start1 = 1'b1;
    ndone = 0; ncodes = 0; seq_ok = 1'b1; prev_code = 4'd0; drop_start = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (drop_start) start1 = 1'b0;
      if (done1) begin
        ndone++;
        drop_start = 1'b1;
      end
      if (busy1) begin
        if (ncodes == 0) begin
          if ({a1, b1, c1, d1} != 4'd0) seq_ok = 1'b0;
          prev_code = {a1, b1, c1, d1};
          ncodes = 1;
        end else if ({a1, b1, c1, d1} != prev_code) begin
          if ({a1, b1, c1, d1} != prev_code + 4'd1) seq_ok = 1'b0;
          prev_code = {a1, b1, c1, d1};
          ncodes++;
        end
      end
    end
    start1 = 1'b0;
    check("held_start done_pulses", 32'(ndone), 32'd1);
    check("held_start code_count",  32'(ncodes), 32'd16);
    check("held_start code_order",  32'(seq_ok), 32'd1);
    check("held_start idle_busy",   32'(busy1), 32'd0);

    // SETTLE_CYCLES=1 with odd parity.
    run_scan(2, 1'b0, 16'h6996, cyc);
    check("parity done_cycle", 32'(cyc), 32'd33);
    check("parity table", 32'(tt2), 32'h6996);
    check("parity cnt",   32'(cnt2), 32'd0);
    check("parity vld",   32'(vld2), 32'd0);
    check("parity pass",  32'(pass2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
